// File: rtl/mc_stage_sequencer.sv
// Multi-cycle control FSM for an RV32I datapath: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// handshakes with instruction and data memory, counts retired instructions and traps on faults.
module mc_stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clear_trap,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic [1:0]           dec_mem_op,
  input  logic                 dec_reg_we,
  input  logic                 dec_branch_jump,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 id_we,
  output logic                 ex_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 busy,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StTrap      = 3'd6
  } state_e;

  localparam int unsigned CntW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = (MEM_TIMEOUT == 0) ? '0 : CntW'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [1:0]             cause_q, cause_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   timeout_hit;

  // The current wait cycle is the MEM_TIMEOUT-th one; an ack in this cycle still wins.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    cnt_d     = cnt_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    id_we     = 1'b0;
    ex_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    trap      = 1'b0;
    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StTrap;
          cause_d = 2'b01;
        end else if (MEM_TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDecode: begin
        id_we = 1'b1;
        if (dec_mem_op == 2'b11) begin
          state_d = StTrap;
          cause_d = 2'b11;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        ex_we   = 1'b1;
        state_d = (dec_mem_op != 2'b00) ? StMemory : StWriteback;
      end
      StMemory: begin
        dmem_req = 1'b1;
        dmem_we  = (dec_mem_op == 2'b10);
        if (dmem_ack) begin
          state_d = StWriteback;
        end else if (timeout_hit) begin
          state_d = StTrap;
          cause_d = 2'b10;
        end else if (MEM_TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWriteback: begin
        rf_we     = dec_reg_we;
        pc_we     = 1'b1;
        pc_sel    = dec_branch_jump;
        instret_d = instret_q + 1'b1;
        state_d   = run ? StFetch : StIdle;
      end
      StTrap: begin
        trap = 1'b1;
        if (clear_trap) begin
          state_d = StIdle;
          cause_d = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cause_q   <= 2'b00;
      instret_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy       = (state_q != StIdle) && (state_q != StTrap);
  assign trap_cause = cause_q;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule
